// File: rtl/risc16_pkg.sv
// Shared encodings for the RiSC-16 multi-cycle controller: opcodes, FSM states,
// ALU function codes, PC/writeback mux selects and the decoded control bundle.
package risc16_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_NAND = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BEQ  = 3'b110,
        OP_JALR = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] FUNC_ADD   = 2'b00;
    localparam logic [1:0] FUNC_NAND  = 2'b01;
    localparam logic [1:0] FUNC_PASS1 = 2'b10;
    localparam logic [1:0] FUNC_EQ    = 2'b11;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_ALU = 2'b10;

    localparam logic [1:0] TGT_ALU = 2'b00;
    localparam logic [1:0] TGT_MEM = 2'b01;
    localparam logic [1:0] TGT_PC  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] mux_pc;
        logic       alu1;
        logic       alu2;
        logic [1:0] func;
        logic       rf_src2_sel;
        logic       rf_we;
        logic [1:0] mux_tgt;
        logic       retire;
    } ctrl_t;

    // SW and BEQ read rA on port 2 (store data / compare operand)
    function automatic logic uses_ra_src2(input opcode_e op);
        return (op == OP_SW) || (op == OP_BEQ);
    endfunction

    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_SW) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/risc16_ctrl_decode.sv
// Combinational control decode: maps FSM state, opcode, imm7, EQ and the memory
// handshake onto the datapath control bundle. Anything not driven stays 0.
module risc16_ctrl_decode
    import risc16_pkg::*;
(
    input  state_e     state_i,
    input  opcode_e    op_i,
    input  logic [6:0] imm7_i,
    input  logic       eq_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    // Per-state, per-opcode control word
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.ir_we   = mem_ready_i;
                ctrl_o.pc_we   = mem_ready_i;
                ctrl_o.mux_pc  = PC_INC;
            end
            ST_DECODE: begin
                ctrl_o.rf_src2_sel = uses_ra_src2(op_i);
            end
            ST_EXEC: begin
                ctrl_o.rf_src2_sel = uses_ra_src2(op_i);
                case (op_i)
                    OP_ADD: begin
                        ctrl_o.func    = FUNC_ADD;
                        ctrl_o.rf_we   = 1'b1;
                        ctrl_o.mux_tgt = TGT_ALU;
                        ctrl_o.retire  = 1'b1;
                    end
                    OP_ADDI: begin
                        ctrl_o.alu2   = 1'b1;
                        ctrl_o.func   = FUNC_ADD;
                        ctrl_o.rf_we  = 1'b1;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_NAND: begin
                        ctrl_o.func   = FUNC_NAND;
                        ctrl_o.rf_we  = 1'b1;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_LUI: begin
                        ctrl_o.alu1   = 1'b1;
                        ctrl_o.func   = FUNC_PASS1;
                        ctrl_o.rf_we  = 1'b1;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_SW, OP_LW: begin
                        ctrl_o.alu2 = 1'b1;
                        ctrl_o.func = FUNC_ADD;
                    end
                    OP_BEQ: begin
                        ctrl_o.func   = FUNC_EQ;
                        ctrl_o.pc_we  = eq_i;
                        ctrl_o.mux_pc = PC_REL;
                        ctrl_o.retire = 1'b1;
                    end
                    OP_JALR: begin
                        // Nonzero imm7 is the halt encoding: nothing is written
                        if (imm7_i == 7'd0) begin
                            ctrl_o.func    = FUNC_PASS1;
                            ctrl_o.rf_we   = 1'b1;
                            ctrl_o.mux_tgt = TGT_PC;
                            ctrl_o.pc_we   = 1'b1;
                            ctrl_o.mux_pc  = PC_ALU;
                            ctrl_o.retire  = 1'b1;
                        end else begin
                            ctrl_o.retire = 1'b0;
                        end
                    end
                    default: begin
                        ctrl_o.retire = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                ctrl_o.rf_src2_sel  = uses_ra_src2(op_i);
                ctrl_o.alu2         = 1'b1;
                ctrl_o.func         = FUNC_ADD;
                ctrl_o.mem_req      = 1'b1;
                ctrl_o.mem_addr_sel = 1'b1;
                ctrl_o.mem_we       = (op_i == OP_SW);
                ctrl_o.rf_we        = mem_ready_i && (op_i == OP_LW);
                ctrl_o.mux_tgt      = (mem_ready_i && (op_i == OP_LW)) ? TGT_MEM : TGT_ALU;
                ctrl_o.retire       = mem_ready_i;
            end
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/risc16_ctrl.sv
// RiSC-16 multi-cycle control FSM: state register, memory wait counter with
// bus-error timeout, and the sticky halted/bus_err flags.
module risc16_ctrl
    import risc16_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] op,
    input  logic [6:0] imm7,
    input  logic       EQ,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] mux_pc,
    output logic       MUX_alu1,
    output logic       MUX_alu2,
    output logic [1:0] FUNC_alu,
    output logic       rf_src2_sel,
    output logic       rf_we,
    output logic [1:0] mux_tgt,
    output logic       retire,
    output logic       halted,
    output logic       bus_err
);

    // The count before the final wait cycle; reaching it with ready low is the timeout
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'd1);
    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            halted_q;
    logic            bus_err_q;
    opcode_e         op_s;
    logic            halt_op_s;
    logic            to_hit_s;
    ctrl_t           ctrl_s;

    assign op_s      = opcode_e'(op);
    assign halt_op_s = (op_s == OP_JALR) && (imm7 != 7'd0);
    assign to_hit_s  = (TIMEOUT != 32'd0) && (cnt_q == TO_LAST);

    risc16_ctrl_decode u_decode (
        .state_i     (state_q),
        .op_i        (op_s),
        .imm7_i      (imm7),
        .eq_i        (EQ),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_s)
    );

    // State sequencing, wait counter and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q   <= '0;
                    state_q <= run ? ST_FETCH : ST_IDLE;
                end
                ST_FETCH, ST_MEM: begin
                    if (mem_ready) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == ST_FETCH) ? ST_DECODE : ST_FETCH;
                    end else if (to_hit_s) begin
                        cnt_q     <= '0;
                        state_q   <= ST_HALT;
                        halted_q  <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_DECODE: begin
                    cnt_q   <= '0;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    cnt_q <= '0;
                    if (is_mem_op(op_s)) begin
                        state_q <= ST_MEM;
                    end else if (halt_op_s) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req      = ctrl_s.mem_req;
    assign mem_we       = ctrl_s.mem_we;
    assign mem_addr_sel = ctrl_s.mem_addr_sel;
    assign ir_we        = ctrl_s.ir_we;
    assign pc_we        = ctrl_s.pc_we;
    assign mux_pc       = ctrl_s.mux_pc;
    assign MUX_alu1     = ctrl_s.alu1;
    assign MUX_alu2     = ctrl_s.alu2;
    assign FUNC_alu     = ctrl_s.func;
    assign rf_src2_sel  = ctrl_s.rf_src2_sel;
    assign rf_we        = ctrl_s.rf_we;
    assign mux_tgt      = ctrl_s.mux_tgt;
    assign retire       = ctrl_s.retire;
    assign halted       = halted_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_risc16_ctrl.sv
// Directed bench for risc16_ctrl: an instruction-level reference model checked
// every cycle, plus hand-computed spot checks at the interesting cycles.
module tb_risc16_ctrl;

    localparam int TO = 4;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_DEC   = 2;
    localparam int M_EXEC  = 3;
    localparam int M_MEM   = 4;
    localparam int M_HALT  = 5;

    logic       clk;
    logic       rst;
    logic       run;
    logic [2:0] op;
    logic [6:0] imm7;
    logic       EQ;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
    logic [1:0] mux_pc;
    logic       MUX_alu1, MUX_alu2;
    logic [1:0] FUNC_alu;
    logic       rf_src2_sel, rf_we;
    logic [1:0] mux_tgt;
    logic       retire, halted, bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    risc16_ctrl #(.TIMEOUT(TO), .TO_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .op           (op),
        .imm7         (imm7),
        .EQ           (EQ),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .mux_pc       (mux_pc),
        .MUX_alu1     (MUX_alu1),
        .MUX_alu2     (MUX_alu2),
        .FUNC_alu     (FUNC_alu),
        .rf_src2_sel  (rf_src2_sel),
        .rf_we        (rf_we),
        .mux_tgt      (mux_tgt),
        .retire       (retire),
        .halted       (halted),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] dut_v;
    assign dut_v = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, mux_pc, MUX_alu1, MUX_alu2,
                    FUNC_alu, rf_src2_sel, rf_we, mux_tgt, retire, halted, bus_err};

    // Instruction-level model: where we are in the instruction, waits so far, flags
    int   m_stage  = M_IDLE;
    int   m_waits  = 0;
    bit   m_halted = 1'b0;
    bit   m_berr   = 1'b0;
    bit   m_valid  = 1'b0;

    // EXEC behaviour of each opcode: ALU function and whether rA is written
    bit [1:0] t_func [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2};
    bit       t_wr   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic logic [17:0] model_out();
        logic mreq, mwe, asel, irwe, pcwe, a1, a2, s2, rfwe, ret, mem_op, stop;
        logic [1:0] mpc, fn, tg;
        {mreq, mwe, asel, irwe, pcwe, a1, a2, s2, rfwe, ret} = 10'd0;
        mpc = 2'd0; fn = 2'd0; tg = 2'd0;
        mem_op = (op == 3'd4) || (op == 3'd5);
        stop   = (op == 3'd7) && (imm7 != 7'd0);
        case (m_stage)
            M_FETCH: begin mreq = 1'b1; irwe = mem_ready; pcwe = mem_ready; end
            M_DEC:   s2 = (op == 3'd4) || (op == 3'd6);
            M_EXEC: if (!stop) begin
                s2   = (op == 3'd4) || (op == 3'd6);
                fn   = t_func[op];
                a1   = (op == 3'd3);
                a2   = (op == 3'd1) || mem_op;
                rfwe = t_wr[op];
                ret  = !mem_op;
                if (op == 3'd6) begin pcwe = EQ; mpc = 2'd1; end
                if (op == 3'd7) begin pcwe = 1'b1; mpc = 2'd2; tg = 2'd2; end
            end
            M_MEM: begin
                mreq = 1'b1; asel = 1'b1; a2 = 1'b1;
                mwe  = (op == 3'd4);
                s2   = (op == 3'd4);
                ret  = mem_ready;
                rfwe = mem_ready && (op == 3'd5);
                tg   = rfwe ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        return {mreq, mwe, asel, irwe, pcwe, mpc, a1, a2, fn, s2, rfwe, tg, ret, m_halted, m_berr};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_stage = M_IDLE; m_waits = 0; m_halted = 1'b0; m_berr = 1'b0; m_valid = 1'b1;
        end else begin
            case (m_stage)
                M_IDLE: if (run) begin m_stage = M_FETCH; m_waits = 0; end
                M_FETCH, M_MEM: begin
                    if (mem_ready) begin
                        m_stage = (m_stage == M_FETCH) ? M_DEC : M_FETCH;
                        m_waits = 0;
                    end else begin
                        m_waits++;
                        if (TO != 0 && m_waits == TO) begin
                            m_stage = M_HALT; m_halted = 1'b1; m_berr = 1'b1;
                        end
                    end
                end
                M_DEC: m_stage = M_EXEC;
                M_EXEC: begin
                    m_waits = 0;
                    if (op == 3'd4 || op == 3'd5) m_stage = M_MEM;
                    else if (op == 3'd7 && imm7 != 7'd0) begin m_stage = M_HALT; m_halted = 1'b1; end
                    else m_stage = M_FETCH;
                end
                default: ;
            endcase
        end
    endtask

    // Every-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        if (m_valid) begin
            n_tests++;
            if (dut_v !== model_out()) begin
                n_fail++;
                $display("FAIL cycle_check t=%0t dut=%b model=%b", $time, dut_v, model_out());
            end
        end
        model_step();
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called one cycle before FETCH is entered (mem_ready high); leaves us in EXEC
    task automatic run_to_exec(input logic [2:0] o, input logic [6:0] im);
        step();
        op = o; imm7 = im;
        settle();
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_ir_we", ir_we, 1);
        step(); settle();
        chk("decode_src2", rf_src2_sel, (o == 3'd4 || o == 3'd6) ? 1 : 0);
        step(); settle();
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; op = 3'd0; imm7 = 7'd0; EQ = 1'b0; mem_ready = 1'b0;
        step(); step(); settle();
        chk("reset_mem_req", mem_req, 0);
        chk("reset_pc_we", pc_we, 0);
        chk("reset_retire", retire, 0);
        chk("reset_halted", halted, 0);
        chk("reset_bus_err", bus_err, 0);
        rst = 1'b0; run = 1'b1; mem_ready = 1'b1;

        // ADD with zero-wait memory
        run_to_exec(3'd0, 7'd0);
        chk("add_rf_we", rf_we, 1);
        chk("add_tgt", mux_tgt, 0);
        chk("add_retire", retire, 1);
        chk("add_pc_we", pc_we, 0);
        run = 1'b0;

        // ADDI / NAND / LUI
        for (int o = 1; o <= 3; o++) begin
            run_to_exec(3'(o), 7'd0);
            chk("alu_func", FUNC_alu, o - 1);
            chk("alu_src1", MUX_alu1, (o == 3) ? 1 : 0);
            chk("alu_src2", MUX_alu2, (o == 1) ? 1 : 0);
            chk("alu_retire", retire, 1);
        end

        // LW with three wait cycles in MEM
        run_to_exec(3'd5, 7'd0);
        chk("lw_exec_alu2", MUX_alu2, 1);
        chk("lw_exec_retire", retire, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) mem_ready = 1'b1;
            settle();
            chk("lw_mem_req", mem_req, 1);
            chk("lw_addr_sel", mem_addr_sel, 1);
            chk("lw_alu2", MUX_alu2, 1);
            chk("lw_mem_we", mem_we, 0);
            chk("lw_rf_we", rf_we, (i == 3) ? 1 : 0);
            chk("lw_tgt", mux_tgt, (i == 3) ? 1 : 0);
            chk("lw_retire", retire, (i == 3) ? 1 : 0);
        end

        // BEQ taken, then not taken
        EQ = 1'b1;
        run_to_exec(3'd6, 7'd0);
        chk("beq_t_pc_we", pc_we, 1);
        chk("beq_t_mux_pc", mux_pc, 1);
        chk("beq_t_func", FUNC_alu, 3);
        chk("beq_t_retire", retire, 1);
        EQ = 1'b0;
        run_to_exec(3'd6, 7'd0);
        chk("beq_nt_pc_we", pc_we, 0);
        chk("beq_nt_retire", retire, 1);

        // SW, zero-wait store
        run_to_exec(3'd4, 7'd0);
        step(); settle();
        chk("sw_mem_we", mem_we, 1);
        chk("sw_rf_we", rf_we, 0);
        chk("sw_retire", retire, 1);

        // JALR link-and-jump, then JALR halt
        run_to_exec(3'd7, 7'd0);
        chk("jalr_rf_we", rf_we, 1);
        chk("jalr_tgt", mux_tgt, 2);
        chk("jalr_pc_we", pc_we, 1);
        chk("jalr_mux_pc", mux_pc, 2);
        chk("jalr_retire", retire, 1);
        run_to_exec(3'd7, 7'd5);
        chk("halt_rf_we", rf_we, 0);
        chk("halt_pc_we", pc_we, 0);
        chk("halt_retire", retire, 0);
        step(); settle();
        chk("halt_flag", halted, 1);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            mem_ready = ~mem_ready;
        end
        settle();
        chk("halt_hold_halted", halted, 1);
        chk("halt_hold_mem_req", mem_req, 0);
        chk("halt_hold_bus_err", bus_err, 0);

        // Reset clears the halt; then FETCH times out after TO waits
        rst = 1'b1; run = 1'b0;
        step(); settle();
        rst = 1'b0;
        chk("rst_clears_halted", halted, 0);
        run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < TO; i++) begin
            step(); settle();
            chk("to_wait_mem_req", mem_req, 1);
            chk("to_wait_bus_err", bus_err, 0);
        end
        step(); settle();
        chk("to_bus_err", bus_err, 1);
        chk("to_halted", halted, 1);
        chk("to_mem_req", mem_req, 0);

        // Ready arriving on the last permitted wait cycle wins
        rst = 1'b1; op = 3'd5; imm7 = 7'd0;
        step(); settle();
        rst = 1'b0;
        chk("rst_clears_bus_err", bus_err, 0);
        for (int i = 0; i < TO; i++) begin
            step();
            if (i == TO - 1) mem_ready = 1'b1;
            settle();
            chk("late_ready_mem_req", mem_req, 1);
        end
        step(); settle();
        chk("late_ready_bus_err", bus_err, 0);
        chk("late_ready_halted", halted, 0);
        chk("late_ready_decode", mem_req, 0);

        // Reset in the middle of a MEM wait, then restart
        mem_ready = 1'b0;
        step(); step(); step(); settle();
        chk("mid_mem_req", mem_req, 1);
        chk("mid_mem_addr_sel", mem_addr_sel, 1);
        rst = 1'b1;
        step(); settle();
        chk("rst_mem_req_drop", mem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire, 0);
        rst = 1'b0;
        step(); settle();
        chk("restart_mem_req", mem_req, 1);
        chk("restart_addr_sel", mem_addr_sel, 0);
        mem_ready = 1'b1;
        step(); step(); step(); settle();
        chk("restart_lw_retire", retire, 1);
        chk("restart_lw_rf_we", rf_we, 1);
        chk("restart_lw_tgt", mux_tgt, 1);
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc16_ctrl.md
Name: risc16_ctrl

Overview:
Multi-cycle control FSM for the RiSC-16 core. It sequences fetch, decode, execute and memory for each instruction, and drives the ALU operand muxes and FUNC_alu, the register-file write, the PC update and the memory request handshake. It sits beside the ALU, register file and PC/IR registers. Its inputs are the IR opcode field, the ALU EQ flag and the memory ready signal.

Parameters:
TIMEOUT, 255, maximum cycles mem_req may wait for mem_ready before a bus error; 0 disables the timeout.
TO_W, 8, width of the wait counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
run  input  1  level; leaves IDLE when high
op  input  3  IR[15:13]
imm7  input  7  IR[6:0]; nonzero with JALR means halt
EQ  input  1  ALU equality flag
mem_ready  input  1  memory completes the current request this cycle
mem_req  output  1  memory request valid
mem_we  output  1  write request (SW)
mem_addr_sel  output  1  0 = PC, 1 = alu_out
ir_we  output  1  load IR from memory read data
pc_we  output  1  PC write enable
mux_pc  output  2  00 PC+1, 01 PC+imm7_sext (PC already incremented), 10 alu_out
MUX_alu1  output  1  ALU SRC1 select (1 = imm<<6)
MUX_alu2  output  1  ALU SRC2 select (1 = imm7_sext)
FUNC_alu  output  2  00 add, 01 nand, 10 pass SRC1, 11 eq
rf_src2_sel  output  1  register-file read port 2 address: 0 = rC, 1 = rA
rf_we  output  1  register-file write enable (rA; writes to r0 discarded by RF)
mux_tgt  output  2  writeback source: 00 alu_out, 01 mem rdata, 10 PC
retire  output  1  one-cycle pulse per completed instruction
halted  output  1  sticky; set by halt or bus error
bus_err  output  1  sticky; set by timeout

Behaviour:
- Reset (synchronous, rst high at a clk edge): state goes to IDLE and the wait counter clears. halted, bus_err and retire all go to 0. All enables and mem_req are low, and every mux output is 0 in IDLE.
- Outputs are a Moore/Mealy mix. Enables are combinational from state, op and the handshake inputs. Unlisted outputs are 0 in each state.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: go to FETCH when run=1.
- FETCH: mem_req=1, mem_addr_sel=0. A transfer occurs on a clk edge where mem_req & mem_ready. In that cycle assert ir_we=1, pc_we=1, mux_pc=00, then go to DECODE. Otherwise stay in FETCH. Zero-wait memory gives a 1-cycle FETCH.
- DECODE: one cycle of register read. rf_src2_sel=1 when op is SW or BEQ. Go to EXEC.
- EXEC, by op (rf_src2_sel held as in DECODE):
  - ADD 000: alu1=0, alu2=0, func=00, rf_we=1, tgt=00. Go to FETCH, retire.
  - ADDI 001: alu2=1, func=00, rf_we=1. Go to FETCH, retire.
  - NAND 010: func=01, rf_we=1. Go to FETCH, retire.
  - LUI 011: alu1=1, func=10, rf_we=1. Go to FETCH, retire.
  - SW 100 / LW 101: alu2=1, func=00. Go to MEM.
  - BEQ 110: func=11. pc_we=EQ, mux_pc=01. Go to FETCH, retire.
  - JALR 111 with imm7==0: func=10, rf_we=1, tgt=10 (old incremented PC), pc_we=1, mux_pc=10. Go to FETCH, retire. The RF write and PC write happen on the same edge, so rA==rB is safe.
  - JALR 111 with imm7!=0: no writes. Go to HALT, set halted.
- MEM: ALU controls held as in EXEC. mem_req=1, mem_addr_sel=1, mem_we=(op==SW). On mem_ready: LW asserts rf_we=1, tgt=01. Go to FETCH, retire.
- HALT: absorbing state; all enables 0. Only rst exits.
- Wait counter: clears on entry to FETCH or MEM and on every completed transfer. Increments each cycle mem_req=1 and mem_ready=0. If TIMEOUT!=0 and the count reaches TIMEOUT with mem_ready still low, go to HALT and set bus_err and halted. mem_ready arriving in that same cycle wins: the transfer completes and there is no error.
- run is sampled only in IDLE. Deasserting run mid-program has no effect.
- Reset mid-request: mem_req drops on the cycle after the reset edge. The memory must tolerate an abandoned request.
- mem_req stays high and mem_addr_sel/mem_we stay stable for the whole wait. Neither changes until the transfer completes.
- Each instruction produces exactly one retire pulse. Halt and bus error produce none.

Decomposition:
- risc16_pkg:
  - opcode enum (OP_ADD..OP_JALR)
  - state enum
  - FUNC_alu codes
  - mux_pc and mux_tgt encodings
- Sub-module risc16_ctrl_decode: combinational op/imm7/EQ/state → control bundle.
- risc16_ctrl keeps the state register, the wait counter and the sticky flags.

Test Plan:
- Reset, then run=1, ADD with mem_ready tied high → FETCH/DECODE/EXEC take 3 cycles. rf_we=1 and tgt=00 in cycle 3, retire=1, pc_we once in FETCH.
- LW with mem_ready low for 3 cycles in MEM → mem_req, mem_addr_sel=1 and alu2=1 stable for 4 cycles. rf_we=1 and tgt=01 only on the ready cycle; mem_we=0.
- BEQ with EQ=1, then EQ=0 → pc_we=1 and mux_pc=01 in EXEC for the first. pc_we=0 for the second. Both retire.
- JALR imm7=0 → rf_we=1, tgt=10, pc_we=1, mux_pc=10 on the same cycle. JALR imm7=5 → HALT, halted=1, no writes, and the state holds for 20 cycles.
- TIMEOUT=4 with mem_ready stuck low in FETCH → bus_err=halted=1 after 4 wait cycles. A variant with mem_ready rising on exactly cycle 4 → no error.
- rst asserted during a MEM wait → the next cycle is IDLE with mem_req=0 and flags cleared. run=1 restarts from FETCH.
